ram_rw_ctrl: RTL
================

// Module: ram_rw_ctrl
// PURPOSE
//  Sequencer directly upstream of the block-RAM wrapper: drives the RAM's enable/write/address/data ports.
//  On a start pulse it fills all DEPTH words with an address-derived pattern, then reads them back.
//  It then reports completion, and (optionally) compares the readback against the expected pattern.
//  Used as the self-test stimulus/checker stage for on-chip RAM IP bring-up.
// PARAMETERS
//  DEPTH   32     number of RAM words exercised; power of two, >=4
//  DW      8      RAM data width
//  AW      $clog2(DEPTH)  address width (derived, not overridden)
//  SEED    8'h10  pattern offset: word[a] = (a + SEED) mod 2^DW
//  RD_LAT  1      RAM read latency in cycles, 1 or 2
// PORTS
//  sys_clk        in   1     clock, all logic on rising edge
//  sys_rst        in   1     reset, asynchronous, active-high
//  start          in   1     one-cycle request to run a write+read pass
//  ram_en         out  1     RAM port enable
//  ram_we         out  1     RAM write enable
//  ram_addr       out  AW    RAM address
//  ram_wdata      out  DW    RAM write data
//  ram_rdata      in   DW    RAM read data, valid RD_LAT cycles after read address
//  busy           out  1     pass in progress
//  done           out  1     one-cycle pulse at end of pass
//  err            out  1     sticky mismatch flag (RAM_CHECK_EN only, else 0)
//  err_cnt        out  AW+1  mismatch count for last pass (RAM_CHECK_EN only, else 0)
// BEHAVIOUR
//  Reset: state IDLE; ram_en, ram_we, ram_addr, ram_wdata, busy, done, err, err_cnt all 0; pipe valids cleared.
//  FSM: IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE. All outputs are registered.
//  IDLE: start=1 -> WRITE. At entry: addr=0; err and err_cnt cleared.
//  WRITE: en=1, we=1, addr 0..DEPTH-1 (one per cycle), wdata=addr+SEED.
//    At addr=DEPTH-1 -> READ, with addr restarting at 0.
//  READ: en=1, we=0, addr 0..DEPTH-1 (one per cycle).
//    Each issued address enters an RD_LAT-deep valid/addr delay line.
//    At addr=DEPTH-1 -> DRAIN.
//  DRAIN: en=0, held RD_LAT cycles until the delay line is empty -> DONE.
//  DONE: done=1 for one cycle, busy=0 -> IDLE.
//  busy=1 in WRITE, READ and DRAIN.
//  Latency: busy lasts 2*DEPTH+RD_LAT cycles; done asserts 2*DEPTH+RD_LAT+1 cycles after the start edge.
//  start while busy or in DONE: ignored, not queued.
//  Address counter wraps naturally at DEPTH (no out-of-range address is ever issued).
//  Reset mid-pass: immediate abort to reset values; no done pulse; the next pass restarts at addr 0.
//  In idle, ram_en=0 and ram_we=0; ram_addr/ram_wdata hold their last values.
// CONFIGURATION
//  Macro RAM_CHECK_EN defined:
//    Each delay-line output with valid=1 compares ram_rdata against (addr_d+SEED).
//    On mismatch: err_cnt+=1 (never exceeds DEPTH, no overflow); err set, sticky until the next start or reset.
//  Macro undefined:
//    No compare logic; err and err_cnt are tied to 0.
//    ram_rdata is unused; FSM timing is identical in both builds.
// STRUCTURE
//  Package ram_ctrl_pkg: state enum (IDLE, WRITE, READ, DRAIN, DONE); function pattern(addr, seed).
//  Sub-module ram_rd_pipe: RD_LAT-deep shift of {valid, addr}; async-high reset clears valids.
//  Top: FSM, address counter, output registers, optional checker.
// TESTING (DEPTH=32, DW=8, SEED=8'h10, behavioural RAM model unless noted)
//  1 Assert sys_rst mid-cycle, no clock -> all outputs 0 immediately (asynchronous).
//  2 RD_LAT=1, start pulse -> 32 writes with addr 0..31, wdata 8'h10..8'h2F;
//    then 32 reads; done at cycle 66; err=0, err_cnt=0.
//  3 RAM_CHECK_EN, model flips bit0 at addr 5 and addr 31 -> err=1, err_cnt=2 at done;
//    a second clean pass clears them to 0.
//  4 start re-pulsed at cycles 10 and 66 (the DONE cycle) -> both ignored;
//    exactly one done pulse; a start at cycle 70 begins a new pass.
//  5 sys_rst pulsed while in WRITE at addr 10 -> outputs 0, no done;
//    a following start writes from addr 0.
//  6 RD_LAT=2, clean model -> done at cycle 67, err_cnt=0.
//    Build without RAM_CHECK_EN plus corrupt model -> err=0, err_cnt=0, same done timing.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared types and helpers for the RAM write/readback sequencer.
package ram_ctrl_pkg;

    // Sequencer states, in the order a pass walks through them.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Address-derived test word. The caller truncates to the RAM data width,
    // which gives the modulo-2^DW wrap of the pattern.
    function automatic logic [31:0] pattern(input logic [31:0] addr, input logic [31:0] seed);
        return addr + seed;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe: RD_LAT-deep delay line of {valid, addr} that lines up each
// issued read address with the RAM data returning for it.
module ram_rd_pipe #(
    parameter int AW     = 5,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr
);

    logic [RD_LAT-1:0] vld_q;
    logic [AW-1:0]     addr_q [RD_LAT];

    // Shift the valid/address pair one stage per clock; reset empties the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= in_valid;
            addr_q[0] <= in_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_addr  = addr_q[RD_LAT-1];

endmodule

// File: rtl/ram_rw_ctrl.sv
// ram_rw_ctrl: block-RAM self-test sequencer. A start pulse fills every word
// with (addr + SEED), reads all words back, then pulses done.
// Defining RAM_CHECK_EN adds a readback checker driving err/err_cnt;
// without it err and err_cnt are tied to 0 and the pass timing is unchanged.
//
// The FSM state and address counter advance first; every port is a register
// loaded from them, so the ports trail the state by one cycle. A start is
// taken only while the ports show idle (busy=0, done=0).
module ram_rw_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int            DEPTH  = 32,
    parameter int            DW     = 8,
    parameter logic [DW-1:0] SEED   = DW'(8'h10),
    parameter int            RD_LAT = 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     start,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [$clog2(DEPTH)-1:0] ram_addr,
    output logic [DW-1:0]            ram_wdata,
    input  logic [DW-1:0]            ram_rdata,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   err_cnt
);

    localparam int            AW        = $clog2(DEPTH);
    localparam int            LW        = 2;  // drain counter, RD_LAT is 1 or 2
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [LW-1:0] LAST_LAT  = LW'(RD_LAT - 1);

    state_t        state, state_n;
    logic [AW-1:0] addr_cnt, addr_n;
    logic [LW-1:0] lat_cnt, lat_n;
    logic          accept;
    logic          rd_vld;
    logic [AW-1:0] rd_addr;

    // Start is honoured only when the sequencer is idle and the outputs say so.
    assign accept = (state == IDLE) && start && !busy && !done;

    // State, address counter and drain counter registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            addr_cnt <= '0;
            lat_cnt  <= '0;
        end else begin
            state    <= state_n;
            addr_cnt <= addr_n;
            lat_cnt  <= lat_n;
        end
    end

    // Next-state logic: one address per cycle in WRITE and READ, RD_LAT cycles in DRAIN.
    always_comb begin
        state_n = state;
        addr_n  = addr_cnt;
        lat_n   = lat_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = WRITE;
                    addr_n  = '0;
                end
            end
            WRITE: begin
                addr_n = addr_cnt + 1'b1;  // wraps to 0 for the read sweep
                if (addr_cnt == LAST_ADDR) begin
                    state_n = READ;
                end
            end
            READ: begin
                addr_n = addr_cnt + 1'b1;
                if (addr_cnt == LAST_ADDR) begin
                    state_n = DRAIN;
                    lat_n   = '0;
                end
            end
            DRAIN: begin
                lat_n = lat_cnt + 1'b1;
                if (lat_cnt == LAST_LAT) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Registered RAM port and status outputs; address and data hold when not sweeping.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            ram_en <= (state == WRITE) || (state == READ);
            ram_we <= (state == WRITE);
            if ((state == WRITE) || (state == READ)) begin
                ram_addr <= addr_cnt;
            end
            if (state == WRITE) begin
                ram_wdata <= DW'(pattern(32'(addr_cnt), 32'(SEED)));
            end
            busy <= (state == WRITE) || (state == READ) || (state == DRAIN);
            done <= (state == DONE);
        end
    end

    // Track which read address the RAM is returning data for.
    ram_rd_pipe #(
        .AW     (AW),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .in_valid  (ram_en && !ram_we),
        .in_addr   (ram_addr),
        .out_valid (rd_vld),
        .out_addr  (rd_addr)
    );

`ifdef RAM_CHECK_EN
    localparam logic [AW:0] CNT_MAX = (AW + 1)'(DEPTH);

    logic [DW-1:0] exp_data;
    logic          mismatch;

    assign exp_data = DW'(pattern(32'(rd_addr), 32'(SEED)));
    assign mismatch = rd_vld && (ram_rdata != exp_data);

    // Sticky error flag and saturating mismatch count, cleared when a pass is accepted.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (accept) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (mismatch) begin
            err <= 1'b1;
            if (err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_rd;

    assign unused_rd = ^{ram_rdata, rd_vld, rd_addr};
    assign err       = 1'b0;
    assign err_cnt   = '0;
`endif

endmodule
